// File: rtl/mux2_sel_arbiter_if.sv
// Handshake and select bundle between the mux2 select arbiter,
// its two sources and the consumer of the mux output.
interface mux2_sel_arbiter_if #(
    parameter int CW = 4
) ();
    logic          req0;
    logic          req1;
    logic          last0;
    logic          last1;
    logic          out_ready;
    logic          sel;
    logic          gnt0;
    logic          gnt1;
    logic          out_valid;
    logic [CW-1:0] beat_cnt;

    // Sources and consumer side
    modport master (
        output req0, req1, last0, last1, out_ready,
        input  sel, gnt0, gnt1, out_valid, beat_cnt
    );

    // Arbiter side
    modport slave (
        input  req0, req1, last0, last1, out_ready,
        output sel, gnt0, gnt1, out_valid, beat_cnt
    );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// Two-source round-robin burst arbiter driving the mux2 select.
// Grants are registered; out_valid is the only combinational output.
module mux2_sel_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int CW        = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux2_sel_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic in_grant;
    logic own;
    logic cur_req;
    logic cur_last;
    logic oth_req;
    logic beat;
    logic burst_end;

    // Fold the owning source's request/last into one view
    always_comb begin
        in_grant  = (state_q != IDLE);
        own       = (state_q == GRANT1);
        cur_req   = own ? bus.req1  : bus.req0;
        cur_last  = own ? bus.last1 : bus.last0;
        oth_req   = own ? bus.req0  : bus.req1;
        beat      = in_grant & cur_req & bus.out_ready;
        burst_end = in_grant &
                    (~cur_req |
                     (beat & (cur_last | (cnt_q == CNT_LAST))));
    end

    // Next-state: pick an owner from IDLE, hand over on burst end
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (!in_grant) begin
            if (bus.req0 && bus.req1) begin
                state_d = prio_q ? GRANT1 : GRANT0;
                sel_d   = prio_q;
            end else if (bus.req0) begin
                state_d = GRANT0;
                sel_d   = 1'b0;
            end else if (bus.req1) begin
                state_d = GRANT1;
                sel_d   = 1'b1;
            end
        end else if (burst_end) begin
            cnt_d  = '0;
            prio_d = ~own;
            if (oth_req) begin
                state_d = own ? GRANT0 : GRANT1;
                sel_d   = ~own;
            end else begin
                state_d = IDLE;
            end
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: grants decode the registered state
    always_comb begin
        bus.sel       = sel_q;
        bus.gnt0      = (state_q == GRANT0);
        bus.gnt1      = (state_q == GRANT1);
        bus.beat_cnt  = cnt_q;
        bus.out_valid = (bus.gnt0 & bus.req0) | (bus.gnt1 & bus.req1);
    end
endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Testbench for mux2_sel_arbiter: directed vector table, hand-written
// corner sequences and random stimulus against a behavioural model.
module tb_mux2_sel_arbiter;
    localparam int BURST_MAX = 4;
    localparam int CW        = 4;

    logic clk;
    logic rst;

    mux2_sel_arbiter_if #(.CW(CW)) ifc ();

    mux2_sel_arbiter #(
        .BURST_MAX(BURST_MAX),
        .CW       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: owner -1 = nobody, else source index
    int m_own, m_cnt, m_prio, m_sel;

    typedef struct {
        bit rs, r0, r1, l0, l1, rdy;
        bit sel, g0, g1;
        int cnt;
        bit ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rs, bit r0, bit r1, bit l0, bit l1,
                                bit rdy, bit sel, bit g0, bit g1,
                                int cnt, bit ov);
        vec_t v;
        v.rs = rs; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
        v.rdy = rdy; v.sel = sel; v.g0 = g0; v.g1 = g1;
        v.cnt = cnt; v.ov = ov;
        return v;
    endfunction

    task automatic model_step(bit rs, bit r0, bit r1, bit l0, bit l1,
                              bit rdy);
        bit rq, ls, acc, oreq;
        int o;
        if (rs) begin
            m_own = -1; m_sel = 0; m_cnt = 0; m_prio = 0;
        end else if (m_own < 0) begin
            if (r0 && r1) m_own = m_prio;
            else if (r0)  m_own = 0;
            else if (r1)  m_own = 1;
            if (m_own >= 0) m_sel = m_own;
        end else begin
            rq  = (m_own == 1) ? r1 : r0;
            ls  = (m_own == 1) ? l1 : l0;
            acc = rq && rdy;
            if (!rq || (acc && (ls || m_cnt + 1 == BURST_MAX))) begin
                m_cnt  = 0;
                o      = 1 - m_own;
                m_prio = o;
                oreq   = (o == 1) ? r1 : r0;
                m_own  = oreq ? o : -1;
                if (m_own >= 0) m_sel = m_own;
            end else if (acc) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check(string name, bit sel, bit g0, bit g1, int cnt,
                         bit ov);
        logic [CW+3:0] act, exp;
        act = {ifc.sel, ifc.gnt0, ifc.gnt1, ifc.beat_cnt, ifc.out_valid};
        exp = {sel, g0, g1, CW'(cnt), ov};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got sel/g0/g1/cnt/ov=%b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
                     name, ifc.sel, ifc.gnt0, ifc.gnt1, ifc.beat_cnt,
                     ifc.out_valid, sel, g0, g1, cnt, ov);
        end
    endtask

    task automatic cyc(bit rs, bit r0, bit r1, bit l0, bit l1, bit rdy);
        rst           = rs;
        ifc.req0      = r0;
        ifc.req1      = r1;
        ifc.last0     = l0;
        ifc.last1     = l1;
        ifc.out_ready = rdy;
        @(posedge clk);
        model_step(rs, r0, r1, l0, l1, rdy);
        #1;
    endtask

    task automatic mcheck(string name);
        bit ov;
        ov = (m_own == 0 && ifc.req0) || (m_own == 1 && ifc.req1);
        check(name, m_sel[0], m_own == 0, m_own == 1, m_cnt, ov);
    endtask

    initial begin
        m_own = -1; m_cnt = 0; m_prio = 0; m_sel = 0;
        rst = 1'b1;
        ifc.req0 = 0; ifc.req1 = 0; ifc.last0 = 0; ifc.last1 = 0;
        ifc.out_ready = 0;

        //             rs r0 r1 l0 l1 rdy sel g0 g1 cnt ov
        tbl.push_back(mk(1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  1, 0, 1, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0));
        // last and BURST_MAX boundary on the same beat
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1,  0, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rs, tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1,
                tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].g0,
                  tbl[i].g1, tbl[i].cnt, tbl[i].ov);
        end

        // Back-pressure: last without ready must not end the burst
        cyc(0, 1, 0, 0, 0, 1); mcheck("bp_grant");
        cyc(0, 1, 0, 0, 0, 1); mcheck("bp_beat");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, i[0], 0, 0);
            check($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 1'b0, 1, 1'b1);
        end
        cyc(0, 1, 1, 0, 0, 1);
        check("bp_resume", 1'b0, 1'b1, 1'b0, 2, 1'b1);
        cyc(0, 0, 0, 0, 0, 1); mcheck("bp_drop");

        // Mid-burst reset during GRANT1 at beat_cnt=2
        cyc(0, 0, 1, 0, 0, 1); mcheck("mr_grant");
        cyc(0, 0, 1, 0, 0, 1); mcheck("mr_b1");
        cyc(0, 0, 1, 0, 0, 1);
        check("mr_cnt2", 1'b1, 1'b0, 1'b1, 2, 1'b1);
        cyc(1, 1, 1, 0, 0, 1);
        check("mr_reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(0, 1, 1, 0, 0, 1);
        check("mr_prio0", 1'b0, 1'b1, 1'b0, 0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0));
            mcheck($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
